// File: rtl/median_row_seq.sv
// Frame sequencer for the three-row median line-buffer: fetches rows from row
// memory, pulses the row-load strobe and hands one window per output row to the writer.
module median_row_seq #(
    parameter int ROWS = 512,
    parameter int AW   = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_valid,
    output logic          ld_en,
    output logic          win_valid,
    output logic [1:0]    win_mode,
    output logic [AW-1:0] out_idx,
    input  logic          wr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ROW    = AW'(ROWS - 1);
    localparam logic [1:0]    MODE_NORMAL = 2'd0;
    localparam logic [1:0]    MODE_TOP    = 2'd1;
    localparam logic [1:0]    MODE_BOTTOM = 2'd2;

    state_t          state_reg, state_next;
    logic [AW-1:0]   fetch_idx_reg, fetch_idx_next;
    logic [AW-1:0]   emit_idx_reg, emit_idx_next;
    logic            fetch_last_reg, fetch_last_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            rd_req_reg, rd_req_next;
    logic [AW-1:0]   rd_addr_reg, rd_addr_next;
    logic            win_valid_reg, win_valid_next;
    logic [1:0]      win_mode_reg, win_mode_next;
    logic [AW-1:0]   out_idx_reg, out_idx_next;

    // fetch_last records that row ROWS-1 has been loaded, so the EMIT decision
    // never depends on fetch_idx, which wraps to 0 when ROWS == 2**AW.
    always_comb begin
        state_next      = state_reg;
        fetch_idx_next  = fetch_idx_reg;
        emit_idx_next   = emit_idx_reg;
        fetch_last_next = fetch_last_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next      = FETCH;
                    fetch_idx_next  = '0;
                    emit_idx_next   = '0;
                    fetch_last_next = 1'b0;
                end
            end
            FETCH: begin
                if (rd_valid) begin
                    fetch_idx_next = fetch_idx_reg + 1'b1;
                    if (fetch_idx_reg == LAST_ROW) begin
                        fetch_last_next = 1'b1;
                    end
                    state_next = (fetch_idx_reg == '0) ? FETCH : EMIT;
                end
            end
            EMIT: begin
                if (wr_ready) begin
                    emit_idx_next = emit_idx_reg + 1'b1;
                    if (emit_idx_reg == LAST_ROW) begin
                        state_next = DONE;
                    end else if (!fetch_last_reg) begin
                        state_next = FETCH;
                    end else begin
                        state_next = EMIT;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next = IDLE;
        end
    end

    // Outputs are decoded from the next state so they leave the flops cleanly.
    always_comb begin
        busy_next      = (state_next == FETCH) || (state_next == EMIT);
        done_next      = (state_next == DONE);
        rd_req_next    = (state_next == FETCH);
        rd_addr_next   = (state_next == FETCH) ? fetch_idx_next : '0;
        win_valid_next = (state_next == EMIT);
        out_idx_next   = (state_next == EMIT) ? emit_idx_next : '0;
        win_mode_next  = MODE_NORMAL;
        if (state_next == EMIT) begin
            if (emit_idx_next == '0) begin
                win_mode_next = MODE_TOP;
            end else if (emit_idx_next == LAST_ROW) begin
                win_mode_next = MODE_BOTTOM;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= IDLE;
            fetch_idx_reg  <= '0;
            emit_idx_reg   <= '0;
            fetch_last_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rd_req_reg     <= 1'b0;
            rd_addr_reg    <= '0;
            win_valid_reg  <= 1'b0;
            win_mode_reg   <= MODE_NORMAL;
            out_idx_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_idx_reg  <= fetch_idx_next;
            emit_idx_reg   <= emit_idx_next;
            fetch_last_reg <= fetch_last_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            rd_req_reg     <= rd_req_next;
            rd_addr_reg    <= rd_addr_next;
            win_valid_reg  <= win_valid_next;
            win_mode_reg   <= win_mode_next;
            out_idx_reg    <= out_idx_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rd_req    = rd_req_reg;
    assign rd_addr   = rd_addr_reg;
    assign win_valid = win_valid_reg;
    assign win_mode  = win_mode_reg;
    assign out_idx   = out_idx_reg;
    assign ld_en     = rd_req_reg & rd_valid;

endmodule

// File: tb/tb_median_row_seq.sv
// Self-checking bench for median_row_seq: three instances (ROWS 3, 4, 512) share
// stimulus; a transfer-order model predicts every cycle of the selected one.
module tb_median_row_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, start, abort, rd_valid, wr_ready;

    logic       busy_a[3], done_a[3], rd_req_a[3], ld_en_a[3], win_valid_a[3];
    logic [8:0] rd_addr_a[3], out_idx_a[3];
    logic [1:0] win_mode_a[3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int R = (gi == 0) ? 3 : ((gi == 1) ? 4 : 512);
        median_row_seq #(.ROWS(R), .AW(9)) u_dut (
            .CLK(CLK), .RST(RST), .start(start), .abort(abort),
            .busy(busy_a[gi]), .done(done_a[gi]),
            .rd_req(rd_req_a[gi]), .rd_addr(rd_addr_a[gi]), .rd_valid(rd_valid),
            .ld_en(ld_en_a[gi]), .win_valid(win_valid_a[gi]),
            .win_mode(win_mode_a[gi]), .out_idx(out_idx_a[gi]), .wr_ready(wr_ready)
        );
    end

    logic [1:0] sel;
    logic       busy, done, rd_req, ld_en, win_valid;
    logic [8:0] rd_addr, out_idx;
    logic [1:0] win_mode;

    always_comb begin
        busy      = busy_a[sel];
        done      = done_a[sel];
        rd_req    = rd_req_a[sel];
        ld_en     = ld_en_a[sel];
        win_valid = win_valid_a[sel];
        rd_addr   = rd_addr_a[sel];
        out_idx   = out_idx_a[sel];
        win_mode  = win_mode_a[sel];
    end

    typedef struct {
        bit f;
        int idx;
    } ev_t;

    int checks = 0;
    int errors = 0;

    function automatic int rows_of(input logic [1:0] s);
        return (s == 2'd0) ? 3 : ((s == 2'd1) ? 4 : 512);
    endfunction

    // Expected order: F0, F1, then E r followed by F(r+2) while rows remain.
    task automatic run_frame(input logic [1:0] si, input int rv_pct, input int wr_pct,
                             input int sf_row, input int sf_n, input int se_row, input int se_n,
                             input int start_at, input int ab_row, input bit pre_abort,
                             input string tag);
        ev_t q[$];
        ev_t h;
        int rows, cyc, sf_left, se_left, budget;
        bit xfer, aborted;
        logic [4:0] exp_ctl, got_ctl;
        logic [8:0] exp_ad, exp_oi;
        logic [1:0] exp_md;
        sel = si;
        rows = rows_of(si);
        q.push_back('{1'b1, 0});
        q.push_back('{1'b1, 1});
        for (int r = 0; r < rows; r++) begin
            q.push_back('{1'b0, r});
            if (r + 2 < rows) q.push_back('{1'b1, r + 2});
        end
        rd_valid = 1'b0; wr_ready = 1'b0;
        if (pre_abort) begin
            abort = 1'b1;
            @(posedge CLK); #1;
            abort = 1'b0;
        end
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        sf_left = sf_n; se_left = se_n; aborted = 1'b0;
        budget = rows * 40 + 50;
        while (q.size() > 0 && cyc < budget) begin
            h = q[0];
            rd_valid = ($urandom_range(99) < rv_pct);
            wr_ready = ($urandom_range(99) < wr_pct);
            if (h.f && h.idx == sf_row && sf_left > 0) begin rd_valid = 1'b0; sf_left--; end
            if (!h.f && h.idx == se_row && se_left > 0) begin wr_ready = 1'b0; se_left--; end
            start = (cyc == start_at);
            abort = (!h.f && h.idx == ab_row);
            @(negedge CLK);
            exp_ctl = {h.f, !h.f, 1'b1, 1'b0, h.f & rd_valid};
            got_ctl = {rd_req, win_valid, busy, done, ld_en};
            exp_ad  = h.f ? 9'(h.idx) : 9'd0;
            exp_oi  = h.f ? 9'd0 : 9'(h.idx);
            exp_md  = h.f ? 2'd0 : ((h.idx == 0) ? 2'd1 : ((h.idx == rows - 1) ? 2'd2 : 2'd0));
            checks += 4;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s ctl cyc %0d: req/wv/busy/done/ld got %b want %b", tag, cyc, got_ctl, exp_ctl);
            end
            if (rd_addr !== exp_ad) begin
                errors++;
                $display("FAIL %s rd_addr cyc %0d: got %0d want %0d", tag, cyc, rd_addr, exp_ad);
            end
            if (out_idx !== exp_oi) begin
                errors++;
                $display("FAIL %s out_idx cyc %0d: got %0d want %0d", tag, cyc, out_idx, exp_oi);
            end
            if (win_mode !== exp_md) begin
                errors++;
                $display("FAIL %s win_mode cyc %0d: got %0d want %0d", tag, cyc, win_mode, exp_md);
            end
            xfer = h.f ? rd_valid : wr_ready;
            if (abort) aborted = 1'b1;
            if (xfer) begin
                $display("%s cyc %0d %s row %0d mode %0d", tag, cyc, h.f ? "fetch" : "emit", h.idx, exp_md);
                void'(q.pop_front());
            end
            @(posedge CLK); #1;
            cyc++;
            if (aborted) break;
        end
        start = 1'b0; abort = 1'b0; rd_valid = 1'b1; wr_ready = 1'b1;
        if (!aborted && q.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s timeout: %0d transfers outstanding after %0d cycles", tag, q.size(), cyc);
            return;
        end
        @(negedge CLK);
        checks++;
        if (aborted) begin
            if ({busy, done, rd_req, win_valid, ld_en, rd_addr, out_idx, win_mode} !== '0) begin
                errors++;
                $display("FAIL %s after_abort: got b%b d%b rq%b wv%b ld%b a%0d o%0d m%0d want all 0",
                         tag, busy, done, rd_req, win_valid, ld_en, rd_addr, out_idx, win_mode);
            end
            $display("%s cyc %0d aborted", tag, cyc);
            return;
        end
        if ({done, busy, rd_req, win_valid, ld_en} !== 5'b10000) begin
            errors++;
            $display("FAIL %s done_cycle cyc %0d: done/busy/req/wv/ld got %b want 10000",
                     tag, cyc, {done, busy, rd_req, win_valid, ld_en});
        end
        if (rv_pct == 100 && wr_pct == 100) begin
            checks++;
            if (cyc !== 2 * rows + 1 + sf_n + se_n) begin
                errors++;
                $display("FAIL %s done_time: got cycle %0d want %0d", tag, cyc, 2 * rows + 1 + sf_n + se_n);
            end
        end
        $display("%s cyc %0d done", tag, cyc);
        @(posedge CLK); #1;
        rd_valid = 1'b0; wr_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, done, rd_req, win_valid, ld_en, rd_addr, out_idx, win_mode} !== '0) begin
            errors++;
            $display("FAIL %s idle_after: got b%b d%b rq%b wv%b a%0d o%0d m%0d want all 0",
                     tag, busy, done, rd_req, win_valid, rd_addr, out_idx, win_mode);
        end
    endtask

    task automatic test_reset();
        sel = 2'd1;
        #12;
        checks++;
        if ({busy, done, rd_req, win_valid, ld_en, rd_addr, out_idx, win_mode} !== '0) begin
            errors++;
            $display("FAIL reset_state: got b%b d%b rq%b wv%b a%0d o%0d m%0d want all 0",
                     busy, done, rd_req, win_valid, rd_addr, out_idx, win_mode);
        end
        #9 RST = 1'b1;
        #3;
    endtask

    task automatic test_zero_wait();
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, -1, 1'b1, "zw4");
        run_frame(2'd0, 100, 100, -1, 0, -1, 0, -1, -1, 1'b1, "zw3");
    endtask

    task automatic test_fetch_stall();
        run_frame(2'd1, 100, 100, 2, 3, -1, 0, -1, -1, 1'b1, "fstall");
    endtask

    task automatic test_emit_stall();
        run_frame(2'd0, 100, 100, -1, 0, 1, 2, -1, -1, 1'b1, "estall");
    endtask

    task automatic test_start_ignored();
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, 5, -1, 1'b1, "startbusy");
    endtask

    task automatic test_abort();
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, 1, 1'b1, "abort");
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, -1, 1'b0, "replay");
    endtask

    task automatic test_start_abort_idle();
        sel = 2'd1;
        @(posedge CLK); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, rd_req, win_valid, done} !== 4'b0000) begin
            errors++;
            $display("FAIL start_abort_idle: busy/req/wv/done got %b want 0000", {busy, rd_req, win_valid, done});
        end
        $display("start_abort_idle stayed idle");
    endtask

    task automatic test_async_reset();
        sel = 2'd1;
        @(posedge CLK); #1;
        start = 1'b1; rd_valid = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_prefetch: req/busy got %b%b want 11", rd_req, busy);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_req, win_valid, ld_en, rd_addr, out_idx, win_mode} !== '0) begin
            errors++;
            $display("FAIL async_reset: got b%b rq%b wv%b ld%b a%0d want all 0", busy, rd_req, win_valid, ld_en, rd_addr);
        end
        $display("async_reset applied mid-fetch");
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1;
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, -1, 1'b0, "postrst");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_frame(2'(k % 2), 60, 60, -1, 0, -1, 0, -1, -1, 1'b1, "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, -1, 1'b1, "b2b_a");
        run_frame(2'd1, 100, 100, -1, 0, -1, 0, -1, -1, 1'b0, "b2b_b");
        run_frame(2'd0, 70, 70, -1, 0, -1, 0, -1, -1, 1'b0, "b2b_c");
    endtask

    task automatic test_rows512();
        run_frame(2'd2, 100, 100, -1, 0, -1, 0, -1, -1, 1'b1, "r512");
        run_frame(2'd2, 80, 80, -1, 0, -1, 0, -1, -1, 1'b0, "r512rand");
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; abort = 1'b0; rd_valid = 1'b0; wr_ready = 1'b0; sel = 2'd1;
        test_reset();
        test_zero_wait();
        test_fetch_stall();
        test_emit_stall();
        test_start_ignored();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_random();
        test_back_to_back();
        test_rows512();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
